// File: rtl/bin_bcd_pkg.sv
// bin_bcd_pkg: shared state type, digit constants and counter sizing for the binary-to-BCD converter
package bin_bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD = 3;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble digit correction, din >= 5 gives din + 3 (ports: din, dout)
module bcd_digit_adjust
  import bin_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);
  assign dout = (din >= BCD_DIGIT_W'(ADJ_THRESH)) ? din + BCD_DIGIT_W'(ADJ_ADD) : din;
endmodule

// File: rtl/bin_bcd_seq_converter.sv
// bin_bcd_seq_converter: sequential W-bit binary to D-digit BCD, one bit per clock, soc/eoc handshake
// ports: clock, reset_ (sync, active-low), soc, x -> eoc, bcd; BIN_BCD_SAT_EN adds ovf and saturates to all 9s
module bin_bcd_seq_converter
  import bin_bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic                     clock,
  input  logic                     reset_,
  input  logic                     soc,
  input  logic [W-1:0]             x,
  output logic                     eoc,
  output logic [BCD_DIGIT_W*D-1:0] bcd
`ifdef BIN_BCD_SAT_EN
  ,
  output logic                     ovf
`endif
);
  localparam int BW = BCD_DIGIT_W * D;
  localparam int CW = cnt_w(W);
  state_t state, state_nx;
  logic [W-1:0] sr;
  logic [BW-1:0] work, adj, work_nx, result;
  logic [CW-1:0] cnt;
  logic last;
  for (genvar i = 0; i < D; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din (work[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  // the bit leaving the top digit is dropped, which keeps the result modulo 10^D
  assign work_nx = BW'({adj, sr[W-1]});
  assign last = cnt == CW'(1);
`ifdef BIN_BCD_SAT_EN
  logic lost, carry;
  assign carry = adj[BW-1];
  assign result = (lost | carry) ? {D{4'h9}} : work_nx;
  always_ff @(posedge clock) begin
    if (!reset_) begin
      lost <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && soc) begin
      lost <= 1'b0;
    end else if (state == SHIFT) begin
      lost <= lost | carry;
      if (last) ovf <= lost | carry;
    end
  end
`else
  assign result = work_nx;
`endif
  always_comb begin
    eoc = state == IDLE;
    state_nx = (state == IDLE) ? (soc ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      sr <= '0;
      work <= '0;
      cnt <= '0;
      bcd <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && soc) begin
        sr <= x;
        work <= '0;
        cnt <= CW'(W);
      end else if (state == SHIFT) begin
        sr <= sr << 1;
        work <= work_nx;
        cnt <= cnt - CW'(1);
        if (last) bcd <= result;
      end
    end
  end
endmodule

// File: tb/tb_bin_bcd_seq_converter.sv
// tb_bin_bcd_seq_converter: scoreboard bench for D=3 and D=2 converters against a decimal reference model
module tb_bin_bcd_seq_converter;
  localparam int W = 8;
`ifdef BIN_BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [11:0] e3;
    logic [7:0]  e2;
    logic        o2;
    int          lat;
  } item_t;
  logic clock = 1'b0;
  logic reset_ = 1'b0;
  logic soc = 1'b0;
  logic [W-1:0] x = '0;
  logic eoc3, eoc2;
  logic [11:0] bcd3;
  logic [7:0] bcd2;
  int vec = 0;
  int misc = 0;
  item_t q[$];
  always #5 clock = ~clock;
`ifdef BIN_BCD_SAT_EN
  logic ovf3, ovf2;
  bin_bcd_seq_converter #(.W(W), .D(3)) u_d3 (.clock(clock), .reset_(reset_), .soc(soc), .x(x), .eoc(eoc3), .bcd(bcd3), .ovf(ovf3));
  bin_bcd_seq_converter #(.W(W), .D(2)) u_d2 (.clock(clock), .reset_(reset_), .soc(soc), .x(x), .eoc(eoc2), .bcd(bcd2), .ovf(ovf2));
`else
  bin_bcd_seq_converter #(.W(W), .D(3)) u_d3 (.clock(clock), .reset_(reset_), .soc(soc), .x(x), .eoc(eoc3), .bcd(bcd3));
  bin_bcd_seq_converter #(.W(W), .D(2)) u_d2 (.clock(clock), .reset_(reset_), .soc(soc), .x(x), .eoc(eoc2), .bcd(bcd2));
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [11:0] ref_bcd(input int v, input int d, input bit sat);
    logic [11:0] r = '0;
    int p = 1;
    int t = v;
    for (int i = 0; i < d; i++) p *= 10;
    if (sat && t >= p) t = p - 1;
    t = t % p;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t /= 10;
    end
    return r;
  endfunction
  function automatic bit legal(input logic [11:0] v, input int d);
    bit ok = 1'b1;
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction
  function automatic item_t mk(input int v, input int lat);
    item_t it;
    it.e3 = ref_bcd(v, 3, SAT);
    it.e2 = 8'(ref_bcd(v, 2, SAT));
    it.o2 = SAT && v >= 100;
    it.lat = lat;
    return it;
  endfunction
  logic prev_eoc = 1'b1;
  int low = 0;
  logic [11:0] last3 = '0;
  logic [7:0] last2 = '0;
  always @(negedge clock) begin
    item_t it;
    if (eoc3 === 1'b0) begin
      low++;
      chk("hold_d3", bcd3, last3);
      chk("hold_d2", bcd2, last2);
    end else if (eoc3 === 1'b1 && prev_eoc === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_eoc", 32'(q.size()), 1);
      end else begin
        it = q.pop_front();
        chk("latency", low, it.lat);
        chk("eoc_d2", eoc2, 1'b1);
        chk("bcd_d3", bcd3, it.e3);
        chk("bcd_d2", bcd2, it.e2);
        chk("digits_d3", legal(bcd3, 3), 1);
        chk("digits_d2", legal({4'h0, bcd2}, 2), 1);
`ifdef BIN_BCD_SAT_EN
        chk("ovf_d3", ovf3, 1'b0);
        chk("ovf_d2", ovf2, it.o2);
`endif
        last3 = it.e3;
        last2 = it.e2;
      end
      low = 0;
    end
    prev_eoc = eoc3;
  end
  task automatic wait_idle();
    int n = 0;
    while (eoc3 !== 1'b1) begin
      if (n >= 40) begin
        $display("FAIL idle_timeout: eoc stuck at %b", eoc3);
        $fatal(1, "idle timeout");
      end
      @(negedge clock);
      n++;
    end
  endtask
  task automatic conv(input int v, input bit hold);
    wait_idle();
    soc = 1'b1;
    x = W'(v);
    @(posedge clock);
    q.push_back(mk(v, W));
    @(negedge clock);
    chk("accept", eoc3, 1'b0);
    soc = hold;
    x = W'($urandom);
  endtask
  initial begin
    int perm[256];
    int n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_eoc", eoc3, 1'b1);
    chk("rst_bcd_d3", bcd3, 0);
    chk("rst_bcd_d2", bcd2, 0);
`ifdef BIN_BCD_SAT_EN
    chk("rst_ovf", ovf2, 1'b0);
`endif
    reset_ = 1'b1;
    foreach (perm[i]) perm[i] = i;
    conv(255, 0);
    conv(0, 0);
    conv(99, 0);
    conv(100, 0);
    conv(7, 1);
    conv(128, 1);
    conv(200, 0);
    conv(255, 0);
    wait_idle();
    soc = 1'b1;
    x = 8'd42;
    @(posedge clock);
    @(negedge clock);
    soc = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_ = 1'b0;
    q.push_back(mk(0, 4));
    @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    conv(42, 0);
    conv(200, 0);
    conv(57, 0);
    for (int i = 255; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    foreach (perm[i]) conv(perm[i], 1'($urandom_range(1, 0)));
    soc = 1'b0;
    wait_idle();
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end
endmodule
